// File: rtl/cpu_datapath.sv
// Bus-centric CPU datapath slice: one-hot selected 32-bit shared bus and the
// Memory Data Register, loaded from the bus or from memory read data.
module cpu_datapath (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] encoder_input,
   input  logic        MDR_enable,
   input  logic        Read,
   input  logic [31:0] MDR_data_in,
   output logic [31:0] bus_data
);
   localparam int DATA_W = 32;

   logic [DATA_W-1:0] gpr [16];
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic [DATA_W-1:0] zhigh;
   logic [DATA_W-1:0] zlow;
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] inport;
   logic [DATA_W-1:0] mdr;
   logic [DATA_W-1:0] mdr_d;
   logic [DATA_W-1:0] C_sign_extended;
   logic [4:0]        src_code;
   logic              src_vld;

   // Immediate source stays zero until the IR/sign-extend block drives it.
   assign C_sign_extended = '0;

   // These registers have no load path yet; they only clear and hold.
   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < 16; i++) begin
            gpr[i] <= '0;
         end
         hi     <= '0;
         lo     <= '0;
         zhigh  <= '0;
         zlow   <= '0;
         pc     <= '0;
         inport <= '0;
      end
   end

   // Scan from the top so the lowest set select bit is the last one written.
   always_comb begin
      src_code = 5'd0;
      src_vld  = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (encoder_input[i]) begin
            src_code = 5'(i);
            src_vld  = 1'b1;
         end
      end
   end

   always_comb begin
      bus_data = '0;
      if (src_vld) begin
         if (src_code < 5'd16) begin
            bus_data = gpr[src_code[3:0]];
         end else begin
            case (src_code)
               5'd16:   bus_data = hi;
               5'd17:   bus_data = lo;
               5'd18:   bus_data = zhigh;
               5'd19:   bus_data = zlow;
               5'd20:   bus_data = pc;
               5'd21:   bus_data = mdr;
               5'd22:   bus_data = inport;
               5'd23:   bus_data = C_sign_extended;
               default: bus_data = '0;
            endcase
         end
      end
   end

   assign mdr_d = Read ? MDR_data_in : bus_data;

   always_ff @(posedge clock) begin
      if (clear) begin
         mdr <= '0;
      end else if (MDR_enable) begin
         mdr <= mdr_d;
      end
   end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized
// traffic compared against a select-priority / MDR reference model.
module tb_cpu_datapath;
   logic        clock;
   logic        clear;
   logic [31:0] encoder_input;
   logic        MDR_enable;
   logic        Read;
   logic [31:0] MDR_data_in;
   logic [31:0] bus_data;

   int vec_cnt;
   int err_cnt;

   logic [31:0] mdr_m;
   logic [31:0] cse_m;

   cpu_datapath dut (
      .clock         (clock),
      .clear         (clear),
      .encoder_input (encoder_input),
      .MDR_enable    (MDR_enable),
      .Read          (Read),
      .MDR_data_in   (MDR_data_in),
      .bus_data      (bus_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected bus value: first set select bit decides; only MDR (21) and
   // the immediate (23) can be non-zero, every other source is held at 0.
   function automatic logic [31:0] ref_bus(input logic [31:0] sel);
      for (int b = 0; b < 32; b++) begin
         if (sel[b]) begin
            if (b == 21) return mdr_m;
            if (b == 23) return cse_m;
            return 32'h0;
         end
      end
      return 32'h0;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   // Advance one rising edge, updating the model from pre-edge inputs.
   task automatic tick();
      logic [31:0] d;
      d = Read ? MDR_data_in : ref_bus(encoder_input);
      if (clear) mdr_m = 32'h0;
      else if (MDR_enable) mdr_m = d;
      @(posedge clock);
      #1;
   endtask

   task automatic set_cse(input logic [31:0] v);
      cse_m = v;
      force dut.C_sign_extended = v;
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      mdr_m   = 32'h0;
      cse_m   = 32'h0;
      clear         = 1'b1;
      encoder_input = 32'h0;
      MDR_enable    = 1'b0;
      Read          = 1'b0;
      MDR_data_in   = 32'h0;

      tick();
      tick();
      clear = 1'b0;
      encoder_input = 32'h00200000; #1;
      check("reset_mdr", bus_data, 32'h0);
      encoder_input = 32'h00000001; #1;
      check("reset_r0", bus_data, 32'h0);

      // Bus to MDR through the immediate source
      set_cse(32'h11111111);
      encoder_input = 32'h00800000; #1;
      check("cse_bus", bus_data, 32'h11111111);
      Read = 1'b0; MDR_enable = 1'b1;
      tick();
      MDR_enable = 1'b0;
      encoder_input = 32'h00200000; #1;
      check("bus_to_mdr", bus_data, 32'h11111111);

      // Memory to MDR
      MDR_data_in = 32'hDEADBEEF; Read = 1'b1; MDR_enable = 1'b1;
      tick();
      MDR_enable = 1'b0; #1;
      check("mem_to_mdr", bus_data, 32'hDEADBEEF);

      // Hold with enable low
      MDR_data_in = 32'h12345678;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mdr_hold", bus_data, 32'hDEADBEEF);
      end

      // Self-select reload leaves MDR unchanged
      Read = 1'b0; MDR_enable = 1'b1;
      tick();
      MDR_enable = 1'b0;
      check("mdr_self", bus_data, 32'hDEADBEEF);

      // Priority and unused/no selects
      encoder_input = 32'h00A00000; #1;
      check("prio_21_23", bus_data, 32'hDEADBEEF);
      encoder_input = 32'h00000000; #1;
      check("sel_none", bus_data, 32'h0);
      encoder_input = 32'h80000000; #1;
      check("sel_unused", bus_data, 32'h0);
      encoder_input = 32'h00200010; #1;
      check("prio_r4_mdr", bus_data, 32'h0);

      // Clear beats enable
      encoder_input = 32'h00200000;
      clear = 1'b1; MDR_enable = 1'b1; Read = 1'b1;
      tick();
      clear = 1'b0; MDR_enable = 1'b0; #1;
      check("clear_prio", bus_data, 32'h0);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         if (n % 25 == 0) set_cse($urandom);
         case ($urandom_range(0, 5))
            0: encoder_input = 32'h1 << $urandom_range(0, 31);
            1: encoder_input = $urandom;
            2: encoder_input = 32'h0;
            3: encoder_input = 32'h00200000 | ($urandom & 32'hFFC00000);
            4: encoder_input = 32'h00800000 | ($urandom & 32'hFF000000);
            default: encoder_input = 32'h00200000;
         endcase
         MDR_enable  = 1'($urandom_range(0, 1));
         Read        = 1'($urandom_range(0, 1));
         MDR_data_in = $urandom;
         clear       = ($urandom_range(0, 15) == 0);
         #1;
         check("rnd_comb", bus_data, ref_bus(encoder_input));
         tick();
         check("rnd_post", bus_data, ref_bus(encoder_input));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
